rom_rr_arbiter: RTL and testbench

//  - Shares one registered single-port ROM (16x4, 1-cycle read latency, sync reset) among NREQ requesters.
//  - Each requester uses a valid/ready handshake. Arbitration is round-robin, one issue per cycle.
//  - Read data returns to the originating requester, tagged with the requester ID.
//  - Sits between client blocks and the ROM instance; it is the only driver of the ROM en/addr pins.

---
 rtl/rom_rr_arbiter_if.sv | 34 +++
 rtl/rom_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_rom_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_rr_arbiter_if.sv
// rom_rr_arbiter_if: request, ROM-port and response signals of the shared-ROM arbiter.
//
// Handshake: requester i presents req_valid[i] with req_addr[i*AW +: AW] and holds
// both stable until req_ready[i] is seen high; a transfer happens on the rising clk
// edge where req_valid[i] & req_ready[i]. req_ready is one-hot or zero. Responses
// have no backpressure: rsp_valid is a one-cycle pulse that must be taken when seen.
interface rom_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic               rom_en;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_data;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;

    // Client/ROM side: drives requests and the ROM read data.
    modport master (
        output req_valid, req_addr, rom_data,
        input  req_ready, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, rom_data,
        output req_ready, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: round-robin arbiter sharing one registered single-port ROM
// (1-cycle read latency) among NREQ requesters; read data returns tagged with
// the requester ID two cycles after acceptance.
// Optional built-in self test (ROM signature scan) enabled by ROM_ARB_BIST_EN.
module rom_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    rom_rr_arbiter_if.slave bus
`ifdef ROM_ARB_BIST_EN
    ,
    input  logic            bist_start,
    output logic            bist_busy,
    output logic            bist_done,
    output logic [DW-1:0]   bist_sig,
    output logic [1:0]      bist_state
`endif
);
    logic [IDW-1:0]  ptr;        // highest-priority requester this cycle
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_idx;
    logic [AW-1:0]   gnt_addr;
    logic            found;
    int              idx;
    logic            block;      // self test owns the ROM port this cycle
    logic            accept;
    logic            scan_issue;
    logic [AW-1:0]   scan_addr;
    logic [IDW-1:0]  s1_id;      // ID of the read currently at the ROM
    logic            s1_bist;    // read at the ROM belongs to the self test

    // Round-robin pick: first valid requester scanning upward from ptr, wrapping.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_addr = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = IDW'(idx);
                gnt_addr   = bus.req_addr[idx*AW +: AW];
            end
        end
    end

    assign accept        = found & ~rst & ~block;
    assign bus.req_ready = accept ? grant : '0;
    // Only forward ROM data while it is known valid; the ROM output is undefined otherwise.
    assign bus.rsp_data  = bus.rsp_valid ? bus.rom_data : '0;

    // Issue stage (ROM en/addr) and response stage; pointer advances past each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rom_en    <= 1'b0;
            bus.rom_addr  <= '0;
            s1_id         <= '0;
            s1_bist       <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            ptr           <= '0;
        end else begin
            bus.rsp_valid <= bus.rom_en & ~s1_bist;
            bus.rsp_id    <= s1_id;
            if (scan_issue) begin
                bus.rom_en   <= 1'b1;
                bus.rom_addr <= scan_addr;
                s1_bist      <= 1'b1;
            end else if (accept) begin
                bus.rom_en   <= 1'b1;
                bus.rom_addr <= gnt_addr;
                s1_id        <= gnt_idx;
                s1_bist      <= 1'b0;
                ptr          <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            end else begin
                bus.rom_en   <= 1'b0;
                s1_bist      <= 1'b0;
            end
        end
    end

`ifdef ROM_ARB_BIST_EN
    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_SCAN  = 2'd1,
        B_DRAIN = 2'd2,
        B_DONE  = 2'd3
    } bist_state_t;

    bist_state_t   state, state_next;
    logic [AW-1:0] scan_cnt;
    logic          drain_cnt;
    logic          s2_bist;      // self-test data is on rom_data this cycle
    logic          in_flight;
    logic          bist_go;
    logic [DW-1:0] sig;

    // A scan may only start once no normal read is still travelling through the pipe.
    assign in_flight = bus.rom_en | bus.rsp_valid | s2_bist;

    // Self-test next state and decoded controls.
    always_comb begin
        state_next = state;
        bist_go    = 1'b0;
        scan_issue = 1'b0;
        block      = 1'b0;
        bist_busy  = 1'b0;
        bist_done  = 1'b0;
        case (state)
            B_IDLE: begin
                if (bist_start && !in_flight) begin
                    bist_go    = 1'b1;
                    block      = 1'b1;
                    state_next = B_SCAN;
                end
            end
            B_SCAN: begin
                scan_issue = 1'b1;
                block      = 1'b1;
                bist_busy  = 1'b1;
                if (scan_cnt == '1) state_next = B_DRAIN;
            end
            B_DRAIN: begin
                if (drain_cnt) state_next = B_DONE;
            end
            B_DONE: begin
                bist_done  = 1'b1;
                state_next = B_IDLE;
            end
            default: state_next = B_IDLE;
        endcase
    end

    // Self-test state register.
    always_ff @(posedge clk) begin
        if (rst) state <= B_IDLE;
        else     state <= state_next;
    end

    // Scan address counter, drain timer and signature accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            drain_cnt <= 1'b0;
            s2_bist   <= 1'b0;
            sig       <= '0;
        end else begin
            s2_bist   <= bus.rom_en & s1_bist;
            drain_cnt <= (state == B_DRAIN) ? ~drain_cnt : 1'b0;
            if (bist_go) begin
                scan_cnt <= '0;
                sig      <= '0;
            end else begin
                if (state == B_SCAN) scan_cnt <= scan_cnt + AW'(1);
                if (s2_bist)         sig      <= sig + bus.rom_data;
            end
        end
    end

    assign scan_addr  = scan_cnt;
    assign bist_sig   = sig;
    assign bist_state = state;
`else
    assign block      = 1'b0;
    assign scan_issue = 1'b0;
    assign scan_addr  = '0;
`endif
endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb_rom_rr_arbiter: table-driven, hand-written and randomized checks of rom_rr_arbiter
// against a transaction-level model (grant pointer plus a queue of due responses).
module tb_rom_rr_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 4;
    localparam int IDW  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) bus ();

`ifdef ROM_ARB_BIST_EN
    logic          bist_start = 1'b0;
    logic          bist_busy;
    logic          bist_done;
    logic [DW-1:0] bist_sig;
    logic [1:0]    bist_state;
`endif

    rom_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ROM_ARB_BIST_EN
        ,
        .bist_start (bist_start),
        .bist_busy  (bist_busy),
        .bist_done  (bist_done),
        .bist_sig   (bist_sig),
        .bist_state (bist_state)
`endif
    );

    // ---------------- ROM model (default contents) ----------------
    logic [DW-1:0] rom_mem [16] = '{4'hF, 4'h7, 4'hB, 4'h1, 4'h9, 4'h2, 4'hC, 4'h3,
                                    4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h9};
    logic [DW-1:0] rom_q;
    always @(posedge clk) begin
        if (rst)             rom_q <= '0;
        else if (bus.rom_en) rom_q <= rom_mem[bus.rom_addr];
        else                 rom_q <= 'x;
    end
    assign bus.rom_data = rom_q;

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t            exp_q[$];
    int              cyc         = 0;
    int              m_ptr       = 0;
    logic            m_rom_en    = 1'b0;
    logic [AW-1:0]   m_rom_addr  = '0;
    logic            m_after_rst = 1'b1;
    logic [NREQ-1:0] m_grant     = '0;

    // Round-robin rule: first requester with valid set, starting at the pointer.
    function automatic int pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Compare registered outputs of the current cycle with the model.
    task automatic check_outputs();
        rsp_t e;
        check("rom_en", bus.rom_en, m_rom_en);
        check("rom_addr", bus.rom_addr, m_rom_addr);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("rsp_valid", bus.rsp_valid, 1);
            check("rsp_id", bus.rsp_id, e.id);
            check("rsp_data", bus.rsp_data, e.data);
        end else begin
            check("rsp_valid_idle", bus.rsp_valid, 0);
            if (m_after_rst) check("rsp_id_reset", bus.rsp_id, 0);
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: check outputs, drive inputs, check grant, advance model, clock edge.
    task automatic step(input logic r, input logic [NREQ-1:0] v,
                        input logic [NREQ*AW-1:0] a, output logic [NREQ-1:0] got);
        int   g;
        rsp_t e;
        @(negedge clk);
        check_outputs();
        rst           = r;
        bus.req_valid = v;
        bus.req_addr  = a;
        #1;
        got     = bus.req_ready;
        m_grant = '0;
        g       = r ? -1 : pick(v, m_ptr);
        if (g >= 0) m_grant[g] = 1'b1;
        check("req_ready", got, m_grant);
        m_after_rst = r;
        if (r) begin
            m_ptr      = 0;
            exp_q.delete();
            m_rom_en   = 1'b0;
            m_rom_addr = '0;
        end else if (g >= 0) begin
            e.due      = cyc + 2;
            e.id       = g;
            e.data     = rom_mem[a[g*AW +: AW]];
            exp_q.push_back(e);
            m_ptr      = (g + 1) % NREQ;
            m_rom_en   = 1'b1;
            m_rom_addr = a[g*AW +: AW];
        end else begin
            m_rom_en   = 1'b0;
        end
        @(posedge clk);
        cyc++;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic               r;
        logic [NREQ-1:0]    v;
        logic [NREQ*AW-1:0] a;
        logic [NREQ-1:0]    e;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic [NREQ-1:0] v, logic [NREQ*AW-1:0] a,
                                logic [NREQ-1:0] e);
        vec_t x;
        x.r = r; x.v = v; x.a = a; x.e = e;
        vecs.push_back(x);
    endfunction

    logic [NREQ-1:0]    got;
    logic [NREQ-1:0]    pend;
    logic [NREQ*AW-1:0] paddr;

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;

        // single request, addr 2
        add(1, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0001, 16'h0002, 4'b0001);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        // all valid from reset, addrs 0,1,4,6: grants 0,1,2,3,0
        add(1, 4'b1111, 16'h6410, 4'b0000);
        add(0, 4'b1111, 16'h6410, 4'b0001);
        add(0, 4'b1111, 16'h6410, 4'b0010);
        add(0, 4'b1111, 16'h6410, 4'b0100);
        add(0, 4'b1111, 16'h6410, 4'b1000);
        add(0, 4'b1111, 16'h6410, 4'b0001);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        // only 2 and 3 valid: alternate 2,3,2,3
        add(1, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b1100, 16'h5300, 4'b0100);
        add(0, 4'b1100, 16'h5300, 4'b1000);
        add(0, 4'b1100, 16'h5300, 4'b0100);
        add(0, 4'b1100, 16'h5300, 4'b1000);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        // idle gaps: requests in cycles 0 and 3 only
        add(1, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0001, 16'h0000, 4'b0001);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0010, 16'h00A0, 4'b0010);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        // pointer at 2 with 0 and 3 valid: wrap to 3 then 0
        add(0, 4'b1001, 16'hE00D, 4'b1000);
        add(0, 4'b1001, 16'hE00D, 4'b0001);
        add(0, 4'b0000, 16'h0000, 4'b0000);
        add(0, 4'b0000, 16'h0000, 4'b0000);

        @(posedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].v, vecs[i].a, got);
            check($sformatf("vec%0d_ready", i), got, vecs[i].e);
        end

        // hand-written: single request returns id 0, data B two cycles later
        step(1, 4'b0000, 16'h0000, got);
        step(0, 4'b0001, 16'h0002, got);
        check("t1_ready", got, 4'b0001);
        step(0, 4'b0000, 16'h0000, got);
        #1;
        check("t1_rsp_valid", bus.rsp_valid, 1);
        check("t1_rsp_id", bus.rsp_id, 0);
        check("t1_rsp_data", bus.rsp_data, 4'hB);
        step(0, 4'b0000, 16'h0000, got);

        // hand-written: reset one cycle after an accept discards the read
        step(0, 4'b0001, 16'h0004, got);
        check("t4_accept", got, 4'b0001);
        step(1, 4'b0001, 16'h0004, got);
        check("t4_ready_in_rst", got, 4'b0000);
        #1;
        check("t4_no_rsp", bus.rsp_valid, 0);
        step(0, 4'b1111, 16'h6410, got);
        check("t4_first_grant", got, 4'b0001);
        step(0, 4'b0000, 16'h0000, got);
        step(0, 4'b0000, 16'h0000, got);
        step(0, 4'b0000, 16'h0000, got);

        // randomized traffic; requesters hold valid/addr until granted
        pend  = '0;
        paddr = '0;
        step(1, 4'b0000, 16'h0000, got);
        for (int n = 0; n < 600; n++) begin
            logic rr;
            rr = ($urandom_range(0, 60) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]           = 1'b1;
                    paddr[i*AW +: AW] = AW'($urandom_range(0, 15));
                end
            end
            step(rr, pend, paddr, got);
            pend = pend & ~m_grant;
        end
        pend = '0;
        step(0, 4'b0000, 16'h0000, got);
        step(0, 4'b0000, 16'h0000, got);
        step(0, 4'b0000, 16'h0000, got);
        step(0, 4'b0000, 16'h0000, got);

`ifdef ROM_ARB_BIST_EN
        begin
            int busy_n;
            int done_n;
            busy_n = 0;
            done_n = 0;
            step(1, 4'b0000, 16'h0000, got);
            step(0, 4'b0000, 16'h0000, got);
            @(negedge clk);
            bist_start = 1'b1;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                bist_start    = 1'b0;
                bus.req_valid = bist_busy ? 4'b1111 : 4'b0000;
                #1;
                if (bist_busy) begin
                    busy_n++;
                    check("bist_ready_blocked", bus.req_ready, 0);
                end
                check("bist_rsp_quiet", bus.rsp_valid, 0);
                if (bist_done) begin
                    done_n++;
                    check("bist_sig_at_done", bist_sig, 4'h6);
                end
            end
            bus.req_valid = '0;
            check("bist_busy_cycles", busy_n, 16);
            check("bist_done_pulses", done_n, 1);
            check("bist_sig_hold", bist_sig, 4'h6);
            // reset aborts a running scan and clears the signature
            @(negedge clk);
            bist_start = 1'b1;
            @(negedge clk);
            bist_start = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("bist_abort_busy", bist_busy, 0);
            check("bist_abort_sig", bist_sig, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
